// File: rtl/uart_rx_reader.sv
// Host-side reader for the UART receive unload handshake.
// Unloads each received byte into a small show-ahead FIFO for the bus side.
module uart_rx_reader #(
  parameter int DEPTH_LOG2  = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  rxclk,
  input  logic                  reset,
  input  logic                  rx_empty,
  output logic                  uld_rx_req,
  input  logic                  uld_rx_ack,
  input  logic [7:0]            rx_data,
  input  logic                  rd_pop,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic                  rd_valid,
  output logic [7:0]            rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {IDLE, REQ, HOLD, CAPTURE, RELEASE} state_t;

  state_t                state;
  logic [7:0]            tcnt;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  ack_expired;

  assign push        = (state == CAPTURE);
  assign pop         = rd_pop && (count != '0);
  assign full        = (count == DEPTH_CNT);
  assign rd_valid    = (count != '0);
  assign rd_data     = mem[rd_ptr];
  assign ack_expired = (({1'b0, tcnt} + 9'd1) >= 9'(ACK_TIMEOUT));

  // A request is only started with a free slot, so CAPTURE can never overflow.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      uld_rx_req  <= 1'b0;
      busy        <= 1'b0;
      tcnt        <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      if (clr_err)
        timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= 8'd0;
          if (!rx_empty && !full && !flush) begin
            state      <= REQ;
            uld_rx_req <= 1'b1;
            busy       <= 1'b1;
          end
        end
        REQ: begin
          if (uld_rx_ack) begin
            state <= HOLD;
          end else begin
            if (tcnt != 8'hFF)
              tcnt <= tcnt + 8'd1;
            if (ack_expired) begin
              state       <= IDLE;
              uld_rx_req  <= 1'b0;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          state      <= CAPTURE;
          uld_rx_req <= 1'b0;
        end
        CAPTURE: begin
          state <= RELEASE;
        end
        RELEASE: begin
          if (!uld_rx_ack) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          uld_rx_req <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Flush outranks a same-edge push or pop; the captured byte is dropped.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 8'd0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rx_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_reader.sv
// Self-checking bench for uart_rx_reader: a cycle-stepped UART model feeds
// bytes, a scoreboard queue holds the bytes the consumer should pop in order.
module tb_uart_rx_reader;

  logic       rxclk = 1'b0;
  logic       reset;
  logic       rx_empty;
  logic       uld_rx_req;
  logic       uld_rx_ack;
  logic [7:0] rx_data;
  logic       rd_pop;
  logic       flush;
  logic       clr_err;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [2:0] count;
  logic       full;
  logic       busy;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int unloads = 0;
  bit ack_enable = 1'b1;
  bit req_d = 1'b0;
  logic [7:0] uart_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    bit         pop;
    int         exp_count;
    bit         exp_full;
  } vec_t;

  vec_t vecs[14];

  uart_rx_reader #(.DEPTH_LOG2(2), .ACK_TIMEOUT(15)) dut (
    .rxclk(rxclk), .reset(reset), .rx_empty(rx_empty), .uld_rx_req(uld_rx_req),
    .uld_rx_ack(uld_rx_ack), .rx_data(rx_data), .rd_pop(rd_pop), .flush(flush),
    .clr_err(clr_err), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .full(full), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 rxclk = ~rxclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock step; the UART acks one cycle after it sees req and drops ack likewise.
  task automatic tick();
    logic new_ack;
    @(posedge rxclk);
    #1;
    new_ack = ack_enable ? req_d : 1'b0;
    if (new_ack && !uld_rx_ack && uart_q.size() > 0) begin
      rx_data = uart_q.pop_front();
      unloads++;
    end
    uld_rx_ack = new_ack;
    req_d      = uld_rx_req;
    rx_empty   = (uart_q.size() == 0);
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    uart_q.push_back(d);
    exp_q.push_back(d);
    rx_empty = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    tick();
    while ((busy || uart_q.size() != 0 || uld_rx_ack) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL wait_done: busy=%0b pending=%0d after %0d cycles", busy, uart_q.size(), n);
    end
  endtask

  task automatic popCheck(input string name);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("[TB] FAIL %s: scoreboard empty, rd_valid=%0b rd_data=0x%0h", name, rd_valid, rd_data);
    end else begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (rd_data !== e || rd_valid !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL %s: rd_data=0x%0h valid=%0b, expected 0x%0h valid=1", name, rd_data, rd_valid, e);
      end
    end
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
  endtask

  task automatic applyVector(input vec_t v, input int idx);
    applyStimulus(v.data);
    waitDone();
    checkOutput($sformatf("vec%0d_count", idx), 32'(count), 32'(v.exp_count));
    checkOutput($sformatf("vec%0d_full", idx), 32'(full), 32'(v.exp_full));
    if (v.pop) begin
      popCheck($sformatf("vec%0d_pop", idx));
      checkOutput($sformatf("vec%0d_count_after_pop", idx), 32'(count), 32'(v.exp_count - 1));
    end
  endtask

  initial begin
    int u0;
    int req_seen;
    int hi_n;

    for (int i = 0; i < 4; i++)
      vecs[i] = '{8'(i + 1), 1'b0, i + 1, (i == 3)};
    for (int i = 0; i < 10; i++)
      vecs[4 + i] = '{8'(8'h10 + i), 1'b1, 1, 1'b0};

    reset = 1'b1; rx_empty = 1'b1; uld_rx_ack = 1'b0; rx_data = 8'h00;
    rd_pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    tickN(2);
    checkOutput("rst_req", 32'(uld_rx_req), 0);
    checkOutput("rst_valid", 32'(rd_valid), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();

    // Single byte with exact handshake timing.
    u0 = unloads;
    applyStimulus(8'hA5);
    tick();
    checkOutput("single_req_rise", 32'(uld_rx_req), 1);
    checkOutput("single_busy", 32'(busy), 1);
    tickN(3);
    checkOutput("single_not_yet", 32'(rd_valid), 0);
    tick();
    checkOutput("single_valid", 32'(rd_valid), 1);
    checkOutput("single_data", 32'(rd_data), 32'hA5);
    checkOutput("single_count", 32'(count), 1);
    tick();
    checkOutput("single_idle_busy", 32'(busy), 0);
    checkOutput("single_idle_req", 32'(uld_rx_req), 0);
    checkOutput("single_unloads", 32'(unloads - u0), 1);
    popCheck("single_pop");
    checkOutput("single_empty", 32'(count), 0);

    // Fill to full, then a fifth byte must wait in the UART.
    for (int i = 0; i < 4; i++) applyVector(vecs[i], i);
    u0 = unloads;
    applyStimulus(8'h05);
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (uld_rx_req) req_seen++;
    end
    checkOutput("full_no_req", 32'(req_seen), 0);
    checkOutput("full_no_unload", 32'(unloads - u0), 0);
    popCheck("full_pop_head");
    waitDone();
    checkOutput("full_refill_unload", 32'(unloads - u0), 1);
    checkOutput("full_refill_count", 32'(count), 4);
    checkOutput("full_refill_full", 32'(full), 1);
    for (int i = 0; i < 4; i++) popCheck($sformatf("full_drain%0d", i));

    // Push and pop on the same edge.
    applyStimulus(8'h55); waitDone();
    applyStimulus(8'h66); waitDone();
    checkOutput("pp_count_pre", 32'(count), 2);
    applyStimulus(8'h77);
    tickN(4);
    popCheck("pp_pop_on_capture");
    checkOutput("pp_count_same", 32'(count), 2);
    waitDone();
    popCheck("pp_pop2");
    popCheck("pp_pop3");

    // Wrap: ten bytes, popped one at a time.
    for (int i = 4; i < 14; i++) applyVector(vecs[i], i);
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
    checkOutput("empty_pop_count", 32'(count), 0);
    checkOutput("empty_pop_valid", 32'(rd_valid), 0);

    // Ack timeout.
    ack_enable = 1'b0;
    applyStimulus(8'h99);
    tick();
    hi_n = 0;
    while (uld_rx_req && hi_n < 40) begin
      hi_n++;
      tick();
    end
    checkOutput("to_req_cycles", 32'(hi_n), 15);
    checkOutput("to_err_set", 32'(timeout_err), 1);
    checkOutput("to_busy", 32'(busy), 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("to_err_clr", 32'(timeout_err), 0);
    tickN(14);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("to_set_beats_clr", 32'(timeout_err), 1);
    checkOutput("to_req_dropped", 32'(uld_rx_req), 0);
    uart_q.delete();
    exp_q.delete();
    rx_empty = 1'b1;
    ack_enable = 1'b1;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("to_err_final", 32'(timeout_err), 0);

    // Flush on the CAPTURE edge discards the byte.
    applyStimulus(8'h31); waitDone();
    u0 = unloads;
    applyStimulus(8'h32);
    tickN(4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    checkOutput("flush_count", 32'(count), 0);
    checkOutput("flush_valid", 32'(rd_valid), 0);
    tick();
    checkOutput("flush_fsm_idle", 32'(busy), 0);
    checkOutput("flush_unloads", 32'(unloads - u0), 1);

    // Asynchronous reset while in HOLD.
    applyStimulus(8'h44);
    tickN(3);
    checkOutput("hold_req", 32'(uld_rx_req), 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("arst_req", 32'(uld_rx_req), 0);
    checkOutput("arst_busy", 32'(busy), 0);
    checkOutput("arst_count", 32'(count), 0);
    checkOutput("arst_valid", 32'(rd_valid), 0);
    checkOutput("arst_full", 32'(full), 0);
    checkOutput("arst_err", 32'(timeout_err), 0);
    checkOutput("arst_data", 32'(rd_data), 0);
    uart_q.delete();
    exp_q.delete();
    uld_rx_ack = 1'b0;
    req_d = 1'b0;
    rx_empty = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    applyStimulus(8'h5A);
    waitDone();
    checkOutput("post_rst_count", 32'(count), 1);
    popCheck("post_rst_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
